// File: rtl/anc_fir_sequencer.sv
// anc_fir_sequencer
//   Sample-rate scheduler for the adaptive FIR weight/output engine.
//
//   Each sample strobe captures a reference sample and computes a weight
//   adjustment: (mu * err) >>> MU_FRAC, saturated to signed 32 bits, or zero
//   when adapt_en is low. The sequencer issues a one-cycle fir_go and holds
//   fir_ff_in / fir_wadj stable until fir_done. It then registers the FIR
//   output as anti_noise_out with a one-cycle anti_noise_valid pulse.
//
//   One further sample can wait in a pending slot while the FIR runs. Further
//   strobes are dropped and counted. A watchdog moves the sequencer to FAULT
//   when fir_done does not arrive within TIMEOUT cycles.
//
//   Optional build macro ANC_SEQ_CLIP_EN additionally clips the weight
//   adjustment to [-CLIP_LIM, +CLIP_LIM] after saturation.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sample_strobe       new ref/err/mu/adapt_en sample valid (1-cycle pulse)
//   ref_sample          signed reference-mic sample
//   err_sample          signed error-mic sample
//   mu, adapt_en        step size and adaptation enable, taken with the strobe
//   fault_clear         leave FAULT (also clears the overrun flag)
//   fir_go              1-cycle start pulse to the FIR
//   fir_ff_in, fir_wadj FIR operands, stable for the whole run
//   fir_out_sample      FIR result
//   fir_done            FIR completion pulse
//   anti_noise_out      last captured FIR result
//   anti_noise_valid    1-cycle pulse when anti_noise_out updates
//   busy, fault         state != IDLE, watchdog fault (sticky)
//   overrun             sticky dropped-sample flag
//   overrun_cnt         saturating dropped-sample count
module anc_fir_sequencer #(
  parameter int MU_W    = 16,
  parameter int MU_FRAC = 15,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16,
  parameter logic signed [31:0] CLIP_LIM = 32'sd1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_strobe,
  input  logic [31:0]      ref_sample,
  input  logic [31:0]      err_sample,
  input  logic [MU_W-1:0]  mu,
  input  logic             adapt_en,
  input  logic             fault_clear,
  output logic             fir_go,
  output logic [31:0]      fir_ff_in,
  output logic [31:0]      fir_wadj,
  input  logic [31:0]      fir_out_sample,
  input  logic             fir_done,
  output logic [31:0]      anti_noise_out,
  output logic             anti_noise_valid,
  output logic             busy,
  output logic             fault,
  output logic             overrun,
  output logic [CNT_W-1:0] overrun_cnt
);

  localparam int PROD_W = MU_W + 32;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

`ifdef ANC_SEQ_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_FAULT
  } state_t;

  function automatic logic signed [31:0] sat32(input logic signed [PROD_W-1:0] v);
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    hi = {{(PROD_W-31){1'b0}}, {31{1'b1}}};
    lo = {{(PROD_W-31){1'b1}}, {31{1'b0}}};
    if (v > hi)      sat32 = 32'sh7FFFFFFF;
    else if (v < lo) sat32 = 32'sh80000000;
    else             sat32 = v[31:0];
  endfunction

  function automatic logic signed [31:0] clip32(input logic signed [31:0] v);
    if (v > CLIP_LIM)       clip32 = CLIP_LIM;
    else if (v < -CLIP_LIM) clip32 = -CLIP_LIM;
    else                    clip32 = v;
  endfunction

  function automatic logic signed [31:0] calc_wadj(input logic signed [MU_W-1:0] m,
                                                   input logic signed [31:0] e,
                                                   input logic en);
    logic signed [PROD_W-1:0] prod;
    logic signed [31:0]       w;
    prod = PROD_W'(m) * PROD_W'(e);
    w = sat32(prod >>> MU_FRAC);
    if (CLIP_ON) w = clip32(w);
    calc_wadj = en ? w : 32'sd0;
  endfunction

  state_t                   state;
  logic signed [31:0]       wadj_new;
  logic [31:0]              pend_ref;
  logic signed [31:0]       pend_wadj;
  logic                     pend_full;
  logic [WD_W-1:0]          wd;
  logic                     drop;
  logic                     take_pend;

  assign wadj_new = calc_wadj($signed(mu), $signed(err_sample), adapt_en);

  // While the FIR is busy the pending slot takes one sample; any further
  // sample is dropped. CAPTURE frees the slot in the same cycle, so it
  // always accepts (handled in the state machine).
  assign drop      = sample_strobe &&  pend_full && (state == S_ISSUE || state == S_WAIT);
  assign take_pend = sample_strobe && !pend_full && (state == S_ISSUE || state == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      fir_go           <= 1'b0;
      fir_ff_in        <= '0;
      fir_wadj         <= '0;
      pend_ref         <= '0;
      pend_wadj        <= '0;
      pend_full        <= 1'b0;
      wd               <= '0;
      anti_noise_out   <= '0;
      anti_noise_valid <= 1'b0;
      busy             <= 1'b0;
      fault            <= 1'b0;
      overrun          <= 1'b0;
      overrun_cnt      <= '0;
    end else begin
      fir_go           <= 1'b0;
      anti_noise_valid <= 1'b0;

      if (fault_clear) overrun <= 1'b0;
      if (drop) begin
        overrun <= 1'b1;
        if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
      if (take_pend) begin
        pend_ref  <= ref_sample;
        pend_wadj <= wadj_new;
        pend_full <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (sample_strobe) begin
            fir_ff_in <= ref_sample;
            fir_wadj  <= wadj_new;
            fir_go    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fir_done) begin
            anti_noise_out   <= fir_out_sample;
            anti_noise_valid <= 1'b1;
            state            <= S_CAPTURE;
          end else if (wd == WD_LAST) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_CAPTURE: begin
          // Promote the pending sample; a strobe now refills the freed slot,
          // or starts the next run directly when nothing was pending.
          if (pend_full) begin
            fir_ff_in <= pend_ref;
            fir_wadj  <= pend_wadj;
            fir_go    <= 1'b1;
            state     <= S_ISSUE;
            if (sample_strobe) begin
              pend_ref  <= ref_sample;
              pend_wadj <= wadj_new;
            end else begin
              pend_full <= 1'b0;
            end
          end else if (sample_strobe) begin
            fir_ff_in <= ref_sample;
            fir_wadj  <= wadj_new;
            fir_go    <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (fault_clear) begin
            fault     <= 1'b0;
            busy      <= 1'b0;
            pend_full <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
